// File: rtl/conv_pixel_feeder.sv
// Host-to-convolution pixel streamer: FIFO-buffered raster input, one frame per start.
// Define CONV_FEEDER_ZERO_PAD_EN to wrap the image in a 1-pixel zero border.
module conv_pixel_feeder #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IMG_WIDTH  = 8,
   parameter int unsigned IMG_HEIGHT = 8,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  start,
   output logic [DATA_WIDTH-1:0] pixel_out,
   output logic                  valid_out,
   output logic                  sof,
   output logic                  eof,
   output logic                  busy,
   output logic                  frame_done,
   output logic [1:0]            dbg_state
);

`ifdef CONV_FEEDER_ZERO_PAD_EN
   localparam int unsigned PAD = 1;
`else
   localparam int unsigned PAD = 0;
`endif
   localparam int unsigned OUT_W = IMG_WIDTH + 2 * PAD;
   localparam int unsigned OUT_H = IMG_HEIGHT + 2 * PAD;
   localparam int unsigned CW    = $clog2(OUT_W) + 1;
   localparam int unsigned RW    = $clog2(OUT_H) + 1;
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Handshake: a host word moves into the FIFO on any rising edge where
   // s_valid && s_ready; s_ready is just "FIFO not full", whatever the FSM does.

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic                  full, empty, push, pop;

   state_e                state_q, state_d;
   logic [RW-1:0]         row_q, row_d;
   logic [CW-1:0]         col_q, col_d;
   logic                  interior, last_col, last_row;

   logic [DATA_WIDTH-1:0] pixel_q, pixel_d;
   logic                  valid_q, valid_d;
   logic                  sof_q, sof_d;
   logic                  eof_q, eof_d;

   assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign s_ready = !full;
   assign push    = s_valid && !full;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s_data;
   end

   assign last_col = (col_q == CW'(OUT_W - 1));
   assign last_row = (row_q == RW'(OUT_H - 1));

`ifdef CONV_FEEDER_ZERO_PAD_EN
   assign interior = (row_q != '0) && !last_row && (col_q != '0) && !last_col;
`else
   assign interior = 1'b1;
`endif

   // The STREAM->DONE move waits one cycle after the eof beat so that
   // frame_done (a DONE decode) lands on the cycle after eof.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      pop     = 1'b0;
      pixel_d = '0;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_STREAM;
               row_d   = '0;
               col_d   = '0;
            end
         end
         ST_STREAM: begin
            if (eof_q) begin
               state_d = ST_DONE;
            end else if (!interior || !empty) begin
               pop     = interior;
               valid_d = 1'b1;
               pixel_d = interior ? mem_q[rd_ptr_q] : '0;
               sof_d   = (row_q == '0) && (col_q == '0);
               eof_d   = last_row && last_col;
               if (last_col) begin
                  col_d = '0;
                  row_d = last_row ? '0 : row_q + RW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         row_q    <= '0;
         col_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pixel_q  <= '0;
         valid_q  <= 1'b0;
         sof_q    <= 1'b0;
         eof_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pixel_q  <= pixel_d;
         valid_q  <= valid_d;
         sof_q    <= sof_d;
         eof_q    <= eof_d;
      end
   end

   assign pixel_out  = pixel_q;
   assign valid_out  = valid_q;
   assign sof        = sof_q;
   assign eof        = eof_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = (state_q == ST_DONE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_conv_pixel_feeder.sv
// Self-checking bench for conv_pixel_feeder (4x4 image, 16-deep FIFO).
// A raster-position model checks every beat against a queue of accepted host words.
module tb_conv_pixel_feeder;

`ifdef CONV_FEEDER_ZERO_PAD_EN
   localparam int PAD = 1;
`else
   localparam int PAD = 0;
`endif
   localparam int EW = 4 + 2 * PAD;
   localparam int EH = 4 + 2 * PAD;
   localparam int NB = EW * EH;

   logic       clk, rst_n;
   logic [7:0] s_data;
   logic       s_valid, s_ready, start;
   logic [7:0] pixel_out;
   logic       valid_out, sof, eof, busy, frame_done;
   logic [1:0] dbg_state;

   conv_pixel_feeder #(
      .DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .FIFO_DEPTH(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .start(start), .pixel_out(pixel_out),
      .valid_out(valid_out), .sof(sof), .eof(eof), .busy(busy),
      .frame_done(frame_done), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         bi = 0;
   int         frames_done = 0;
   int         beats_total = 0;
   logic       prev_eof = 1'b0;
   logic       prev_fd = 1'b0;
   logic [7:0] exp_q[$];

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // scoreboard: outputs are compared before this cycle's accept is queued
   always @(negedge clk) begin : monitor
      int         r, c;
      logic       inner;
      logic [7:0] exp_pix;
      if (!rst_n) begin
         bi = 0;
         exp_q.delete();
         prev_eof = 1'b0;
         prev_fd  = 1'b0;
      end else begin
         if (valid_out) begin
            r = bi / EW;
            c = bi % EW;
            inner = (r >= PAD) && (r < EH - PAD) && (c >= PAD) && (c < EW - PAD);
            if (inner) begin
               check("exp_avail", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  exp_pix = exp_q.pop_front();
                  check("pixel", pixel_out, exp_pix);
               end
            end else begin
               check("pixel_border", pixel_out, 0);
            end
            check("sof", sof, bi == 0);
            check("eof", eof, bi == NB - 1);
            bi = (bi == NB - 1) ? 0 : bi + 1;
            beats_total++;
         end else if (busy) begin
            check("bubble_zero", {pixel_out, sof, eof}, 0);
         end
         if (frame_done) frames_done++;
         check("fd_after_eof", frame_done, prev_eof);
         if (prev_fd) check("busy_after_fd", busy, 0);
         prev_eof = valid_out && eof;
         prev_fd  = frame_done;
         if (s_valid && s_ready) exp_q.push_back(s_data);
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pixel(input logic [7:0] d);
      int guard = 0;
      s_valid = 1'b1;
      s_data  = d;
      while (!s_ready && guard < 500) begin
         tick();
         guard++;
      end
      check("push_wait", guard < 500, 1);
      tick();
      s_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_frames(input int target, input string name);
      int guard = 0;
      while (frames_done < target && guard < 2000) begin
         tick();
         guard++;
      end
      check(name, frames_done >= target, 1);
   endtask

   typedef struct {
      logic       s_valid;
      logic [7:0] s_data;
      logic       exp_ready;
   } vec_t;

   vec_t vecs[18];

   initial begin : test
      int f0, b0, cycles, guard;

      for (int i = 0; i < 18; i++) begin
         vecs[i].s_valid   = 1'b1;
         vecs[i].s_data    = (i < 16) ? 8'(8'h40 + i) : 8'h50;
         vecs[i].exp_ready = (i < 16);
      end

      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; start = 1'b0;
      tick();
      tick();
      check("rst_pixel", pixel_out, 0);
      check("rst_valid", valid_out, 0);
      check("rst_sof_eof", {sof, eof}, 0);
      check("rst_busy", busy, 0);
      check("rst_fd", frame_done, 0);
      check("rst_ready", s_ready, 1);
      check("rst_state", dbg_state, 0);
      rst_n = 1'b1;
      tick();

      // prefilled frame, back-to-back
      for (int i = 0; i < 16; i++) push_pixel(8'(i));
      pulse_start();
      check("busy_on_start", busy, 1);
      check("no_beat_at_start", valid_out, 0);
      tick();
      check("first_beat", valid_out, 1);
      check("first_sof", sof, 1);
      cycles = 1;
      while (!frame_done && cycles < 200) begin
         tick();
         cycles++;
      end
      check("prefill_cycles", cycles, NB + 1);
      check("busy_with_fd", busy, 1);
      tick();
      check("busy_dropped", busy, 0);
      check("fd_one_cycle", frame_done, 0);

      // start during STREAM is ignored
      for (int i = 0; i < 16; i++) push_pixel(8'(8'h20 + i));
      f0 = frames_done;
      b0 = beats_total;
      pulse_start();
      repeat (5) tick();
      pulse_start();
      wait_frames(f0 + 1, "ign_frame_done");
      repeat (6) tick();
      check("ign_one_frame", frames_done, f0 + 1);
      check("ign_beats", beats_total, b0 + NB);
      check("ign_idle", busy, 0);

      // starved source: one pixel every 3 cycles
      f0 = frames_done;
      pulse_start();
      for (int i = 0; i < 16; i++) begin
         push_pixel(8'(8'h60 + i));
`ifndef CONV_FEEDER_ZERO_PAD_EN
         tick();
         check("starve_latency", valid_out, 1);
         tick();
         check("starve_bubble", valid_out, 0);
`else
         tick();
         tick();
`endif
      end
      wait_frames(f0 + 1, "starve_frame_done");
      tick();

      // FIFO full in IDLE, then remainder accepted as the frame drains
      for (int i = 0; i < 18; i++) begin
         s_valid = vecs[i].s_valid;
         s_data  = vecs[i].s_data;
         check("full_ready", s_ready, vecs[i].exp_ready);
         tick();
      end
      f0 = frames_done;
      pulse_start();
      for (int i = 0; i < 4; i++) push_pixel(8'(8'h50 + i));
      wait_frames(f0 + 1, "full_frame_done");
      tick();
      // leftovers 0x50..0x53 lead the next frame
      for (int i = 4; i < 16; i++) push_pixel(8'(8'h50 + i));
      check("leftover_ready", s_ready, 0);
      pulse_start();
      wait_frames(f0 + 2, "leftover_frame_done");
      tick();

      // reset in the middle of a frame
      for (int i = 0; i < 16; i++) push_pixel(8'(8'h70 + i));
      pulse_start();
      guard = 0;
      while (bi < 8 && guard < 200) begin
         tick();
         guard++;
      end
      check("mid_reach_beat8", bi >= 8, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_outputs", {pixel_out, valid_out, sof, eof}, 0);
      check("mid_rst_busy_fd", {busy, frame_done}, 0);
      check("mid_rst_ready", s_ready, 1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      f0 = frames_done;
      for (int i = 0; i < 16; i++) push_pixel(8'(8'h80 + i));
      pulse_start();
      wait_frames(f0 + 1, "post_rst_frame_done");
      repeat (3) tick();
      check("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
